// File: rtl/data_lsu_pkg.sv
// Shared definitions for the data load/store unit: width codes, FSM states,
// default RAM size and request-decode helpers.
package data_lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Stores only have signed-style codes; bu/hu make no sense for a write.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts/extends load data and merges sub-word store
// data into a full RAM word. Purely combinational.
module lsu_lane_align
    import data_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (offset_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (offset_i)
                    2'd0: merge_o[7:0]   = wdata_i[7:0];
                    2'd1: merge_o[15:8]  = wdata_i[7:0];
                    2'd2: merge_o[23:16] = wdata_i[7:0];
                    2'd3: merge_o[31:24] = wdata_i[7:0];
                    default: merge_o = word_i;
                endcase
            end
            F3_H: begin
                if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
                else             merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Load/store initiator for a word-organised data RAM; sub-word stores are
// done as read-modify-write. One request in flight at a time.
module data_lsu
    import data_lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        ram_we,
    output logic        ram_re,
    output logic [31:0] ram_a,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd,
    output state_e      dbg_state
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // req_ready is high only in IDLE. The response is a single-cycle rsp_valid
    // pulse with no backpressure; rsp_err/rsp_rdata hold until the next response.

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [31:0] word_idx;
    logic [31:0] lane_word;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    assign req_err = !f3_legal(req_we, req_funct3)
                   || f3_misaligned(req_funct3, req_addr[1:0])
                   || ({2'b00, req_addr[31:2]} >= WORD_LIMIT);

    assign word_idx  = {2'b00, addr_q[31:2]};
    // The aligner sees live RAM data while loading and the saved word while merging.
    assign lane_word = (state_q == ST_LOAD) ? ram_rd : merge_q;

    lsu_lane_align u_align (
        .word_i   (lane_word),
        .wdata_i  (wdata_q),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = (state_q == ST_IDLE);
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_a     = 32'h0;
        ram_wd    = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                ram_re  = 1'b1;
                ram_a   = word_idx;
                rdata_d = lane_load;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_STORE: begin
                ram_we  = 1'b1;
                ram_a   = word_idx;
                ram_wd  = wdata_q;
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                ram_re  = 1'b1;
                ram_a   = word_idx;
                merge_d = ram_rd;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                ram_we  = 1'b1;
                ram_a   = word_idx;
                ram_wd  = lane_merge;
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;
    assign dbg_state = state_q;

endmodule
